// File: rtl/spi_pixel_receiver_if.sv
// Pixel-receiver bus: the host SPI pins going in and the frame-RAM write port
// plus buffer and status flags coming out.
interface spi_pixel_receiver_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              spi_clk;
  logic              spi_mosi;
  logic [ADDR_W-1:0] fb_write_addr;
  logic [DATA_W-1:0] fb_write_data;
  logic              fb_write_en;
  logic              write_buffer;
  logic              display_buffer;
  logic              frame_done;
  logic              sync_error;

  modport slave (
    input  spi_clk, spi_mosi,
    output fb_write_addr, fb_write_data, fb_write_en,
           write_buffer, display_buffer, frame_done, sync_error
  );

  modport master (
    output spi_clk, spi_mosi,
    input  fb_write_addr, fb_write_data, fb_write_en,
           write_buffer, display_buffer, frame_done, sync_error
  );
endinterface

// File: rtl/spi_pixel_receiver.sv
// Receives the host's MSB-first SPI pixel stream in the pixel_clk domain and
// writes whole words into the double-buffered frame RAM, swapping halves per frame.
module spi_pixel_receiver #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 32,
  parameter int PIXEL_BITS   = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  spi_pixel_receiver_if.slave  bus
);
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT);
  localparam int BIT_W  = $clog2(PIXEL_BITS);
  localparam int TO_W   = $clog2(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_PIXEL  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(PIXEL_BITS - 1);
  localparam logic [TO_W-1:0]   TIMEOUT_MAX = TO_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, RECV} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sclkSync_q, mosiSync_q;
  logic                  sclkPrev_q;
  logic [PIXEL_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bitCount_q, bitCount_d;
  logic [ADDR_W-1:0]     pixelCount_q, pixelCount_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic                  wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]     wrAddr_q, wrAddr_d;
  logic [PIXEL_BITS-1:0] wrData_q, wrData_d;
  logic                  writeBuf_q, writeBuf_d;
  logic                  frameDone_q, frameDone_d;
  logic                  syncErr_q, syncErr_d;
  logic                  rise, mosiBit;

  // mosi comes from the same stage as the clock so a bit lines up with its edge
  assign rise    = sclkSync_q[1] & ~sclkPrev_q;
  assign mosiBit = mosiSync_q[1];

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitCount_d   = bitCount_q;
    pixelCount_d = pixelCount_q;
    timeout_d    = timeout_q;
    wrEn_d       = 1'b0;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    writeBuf_d   = writeBuf_q;
    frameDone_d  = 1'b0;
    syncErr_d    = 1'b0;

    if (rise) begin
      shift_d    = {shift_q[PIXEL_BITS-2:0], mosiBit};
      bitCount_d = bitCount_q + 1'b1;
      timeout_d  = '0;
      state_d    = RECV;
      if (bitCount_q == LAST_BIT) begin
        wrEn_d   = 1'b1;
        wrData_d = {shift_q[PIXEL_BITS-2:0], mosiBit};
        wrAddr_d = pixelCount_q;
        // the last pixel index holds until the swap clears it, so it never wraps
        if (pixelCount_q != LAST_PIXEL)
          pixelCount_d = pixelCount_q + 1'b1;
      end
    end else if (state_q == RECV) begin
      if (timeout_q == TIMEOUT_MAX) begin
        shift_d      = '0;
        bitCount_d   = '0;
        pixelCount_d = '0;
        timeout_d    = '0;
        syncErr_d    = 1'b1;
        state_d      = IDLE;
      end else begin
        timeout_d = timeout_q + 1'b1;
      end
    end

    // the swap trails the final write by one cycle
    if (wrEn_q && (wrAddr_q == LAST_PIXEL)) begin
      frameDone_d  = 1'b1;
      writeBuf_d   = ~writeBuf_q;
      pixelCount_d = '0;
      timeout_d    = '0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sclkSync_q   <= '0;
      mosiSync_q   <= '0;
      sclkPrev_q   <= 1'b0;
      shift_q      <= '0;
      bitCount_q   <= '0;
      pixelCount_q <= '0;
      timeout_q    <= '0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      writeBuf_q   <= 1'b0;
      frameDone_q  <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclkSync_q   <= {sclkSync_q[0], bus.spi_clk};
      mosiSync_q   <= {mosiSync_q[0], bus.spi_mosi};
      sclkPrev_q   <= sclkSync_q[1];
      shift_q      <= shift_d;
      bitCount_q   <= bitCount_d;
      pixelCount_q <= pixelCount_d;
      timeout_q    <= timeout_d;
      wrEn_q       <= wrEn_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
      writeBuf_q   <= writeBuf_d;
      frameDone_q  <= frameDone_d;
      syncErr_q    <= syncErr_d;
    end
  end

  assign bus.fb_write_en    = wrEn_q;
  assign bus.fb_write_addr  = wrAddr_q;
  assign bus.fb_write_data  = wrData_q;
  assign bus.write_buffer   = writeBuf_q;
  assign bus.display_buffer = ~writeBuf_q;
  assign bus.frame_done     = frameDone_q;
  assign bus.sync_error     = syncErr_q;
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Bench for spi_pixel_receiver on a reduced 8x4 panel: a scoreboard queue holds
// the expected frame-RAM writes and a negedge monitor retires them.
module tb_spi_pixel_receiver;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int ADDR_W = 5;
  localparam int HALF   = 4;
  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NPIX - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic pixelClk = 1'b0;
  logic reset    = 1'b1;

  spi_pixel_receiver_if #(.ADDR_W(ADDR_W), .DATA_W(16)) bus ();

  spi_pixel_receiver #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_BITS(16), .IDLE_TIMEOUT(1024)
  ) dut (
    .pixel_clk(pixelClk),
    .reset(reset),
    .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  wr_t  expQ[$];
  int   expPix = 0;
  int   cyc = 0;
  int   lastRiseCyc = 0;
  int   writesSeen = 0;
  int   doneSeen = 0;
  int   syncSeen = 0;
  bit   doneDue = 1'b0;
  logic wbModel = 1'b0;

  always #5 pixelClk = ~pixelClk;

  always @(posedge pixelClk) cyc <= cyc + 1;

  // Monitor: retires expected writes and checks swap timing and buffer parity
  always @(negedge pixelClk) begin
    wr_t e;
    int  lat;
    if (reset) begin
      expQ.delete();
      doneDue = 1'b0;
      wbModel = 1'b0;
    end else begin
      if (doneDue || bus.frame_done) begin
        total++;
        if (bus.frame_done !== doneDue) begin
          bad++;
          $display("[TB] FAIL frame_done_timing: got %b expected %b", bus.frame_done, doneDue);
        end
        if (doneDue) wbModel = ~wbModel;
        total++;
        if (bus.write_buffer !== wbModel || bus.display_buffer !== ~wbModel) begin
          bad++;
          $display("[TB] FAIL buffer_swap: got wb=%b db=%b expected wb=%b db=%b",
                   bus.write_buffer, bus.display_buffer, wbModel, ~wbModel);
        end
      end
      doneDue = 1'b0;
      if (bus.frame_done === 1'b1) doneSeen++;
      if (bus.sync_error === 1'b1) syncSeen++;
      if (bus.fb_write_en === 1'b1) begin
        writesSeen++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=%h expected no write",
                   bus.fb_write_addr, bus.fb_write_data);
        end else begin
          e = expQ.pop_front();
          if (bus.fb_write_addr !== e.addr) begin
            bad++;
            $display("[TB] FAIL write_addr: got %0d expected %0d", bus.fb_write_addr, e.addr);
          end
          total++;
          if (bus.fb_write_data !== e.data) begin
            bad++;
            $display("[TB] FAIL write_data: got %h expected %h", bus.fb_write_data, e.data);
          end
          lat = cyc - lastRiseCyc;
          total++;
          if (lat < 3 || lat > 4) begin
            bad++;
            $display("[TB] FAIL write_latency: got %0d expected 3..4", lat);
          end
          if (e.addr == LAST_PIXEL) doneDue = 1'b1;
        end
      end
    end
  end

  task automatic applyReset();
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge pixelClk);
    reset  = 1'b0;
    expPix = 0;
    repeat (2) @(negedge pixelClk);
  endtask

  // Drives bits [15-first .. 15-first-n+1] of w; completing bit 15 queues the write
  task automatic applyStimulus(input logic [15:0] w, input int first, input int n);
    wr_t e;
    for (int i = first; i < first + n; i++) begin
      bus.spi_mosi = w[15-i];
      bus.spi_clk  = 1'b0;
      repeat (HALF) @(negedge pixelClk);
      bus.spi_clk = 1'b1;
      if (i == 15) begin
        e.addr = ADDR_W'(expPix);
        e.data = w;
        expQ.push_back(e);
        lastRiseCyc = cyc;
        expPix = (expPix == NPIX - 1) ? 0 : expPix + 1;
      end
      repeat (HALF) @(negedge pixelClk);
    end
  endtask

  task automatic checkCounts(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic checkResetValues(input string name);
    total++;
    if (bus.fb_write_en !== 1'b0 || bus.fb_write_addr !== '0 || bus.fb_write_data !== '0 ||
        bus.write_buffer !== 1'b0 || bus.display_buffer !== 1'b1 ||
        bus.frame_done !== 1'b0 || bus.sync_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: got en=%b addr=%0d data=%h wb=%b db=%b fd=%b se=%b expected 0,0,0,0,1,0,0",
               name, bus.fb_write_en, bus.fb_write_addr, bus.fb_write_data, bus.write_buffer,
               bus.display_buffer, bus.frame_done, bus.sync_error);
    end
  endtask

  task automatic test_reset();
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge pixelClk);
    checkResetValues("reset_values");
    reset = 1'b0;
    repeat (2) @(negedge pixelClk);
  endtask

  task automatic test_single_word();
    int w0;
    applyReset();
    w0 = writesSeen;
    applyStimulus(16'hF0A0, 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("single_word_writes", writesSeen - w0, 1);
    checkCounts("single_word_queue", expQ.size(), 0);
    total++;
    if (bus.fb_write_en !== 1'b0 || bus.fb_write_addr !== '0 || bus.fb_write_data !== 16'hF0A0) begin
      bad++;
      $display("[TB] FAIL single_word_hold: got en=%b addr=%0d data=%h expected 0,0,f0a0",
               bus.fb_write_en, bus.fb_write_addr, bus.fb_write_data);
    end
  endtask

  task automatic test_full_frame();
    int w0, d0, s0;
    applyReset();
    w0 = writesSeen; d0 = doneSeen; s0 = syncSeen;
    for (int k = 0; k < NPIX; k++) applyStimulus(16'(k * 16'h0421), 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("frame_writes", writesSeen - w0, NPIX);
    checkCounts("frame_done_count", doneSeen - d0, 1);
    checkCounts("frame_sync_errors", syncSeen - s0, 0);
    checkCounts("frame_write_buffer", int'(bus.write_buffer), 1);
    checkCounts("frame_display_buffer", int'(bus.display_buffer), 0);
  endtask

  task automatic test_back_to_back();
    int d0;
    applyReset();
    d0 = doneSeen;
    for (int k = 0; k < 2 * NPIX; k++) applyStimulus(16'($urandom), 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("b2b_done_count", doneSeen - d0, 2);
    checkCounts("b2b_write_buffer", int'(bus.write_buffer), 0);
    checkCounts("b2b_queue", expQ.size(), 0);
  endtask

  task automatic test_timeout_partial();
    int w0, s0, d0;
    applyReset();
    w0 = writesSeen; s0 = syncSeen; d0 = doneSeen;
    applyStimulus(16'hABCD, 0, 10);
    repeat (1100) @(negedge pixelClk);
    checkCounts("partial_sync_error", syncSeen - s0, 1);
    checkCounts("partial_no_write", writesSeen - w0, 0);
    checkCounts("partial_no_done", doneSeen - d0, 0);
    expPix = 0;
    applyStimulus(16'h1357, 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("partial_next_write", writesSeen - w0, 1);
    checkCounts("partial_write_buffer", int'(bus.write_buffer), 0);
  endtask

  task automatic test_slow_gap();
    int w0, s0;
    applyReset();
    w0 = writesSeen; s0 = syncSeen;
    applyStimulus(16'h5AC3, 0, 8);
    repeat (900) @(negedge pixelClk);
    applyStimulus(16'h5AC3, 8, 8);
    repeat (10) @(negedge pixelClk);
    checkCounts("gap_no_sync_error", syncSeen - s0, 0);
    checkCounts("gap_one_write", writesSeen - w0, 1);
  endtask

  task automatic test_stall_resync();
    int s0, d0;
    applyReset();
    s0 = syncSeen; d0 = doneSeen;
    for (int k = 0; k < 10; k++) applyStimulus(16'(16'h8000 + k), 0, 16);
    repeat (2000) @(negedge pixelClk);
    expPix = 0;
    for (int k = 0; k < NPIX; k++) applyStimulus(16'($urandom), 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("stall_sync_error", syncSeen - s0, 1);
    checkCounts("stall_done_count", doneSeen - d0, 1);
    checkCounts("stall_write_buffer", int'(bus.write_buffer), 1);
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    applyReset();
    for (int k = 0; k < NPIX; k++) applyStimulus(16'($urandom), 0, 16);
    for (int k = 0; k < 20; k++) applyStimulus(16'($urandom), 0, 16);
    applyStimulus(16'hFFFF, 0, 7);
    bus.spi_mosi = 1'b1;
    bus.spi_clk  = 1'b0;
    repeat (HALF) @(negedge pixelClk);
    bus.spi_clk = 1'b1;
    repeat (2) @(negedge pixelClk);
    reset = 1'b1;
    bus.spi_clk = 1'b0;
    repeat (2) @(negedge pixelClk);
    checkResetValues("midframe_reset_values");
    reset  = 1'b0;
    expPix = 0;
    repeat (2) @(negedge pixelClk);
    w0 = writesSeen;
    applyStimulus(16'h2468, 0, 16);
    repeat (10) @(negedge pixelClk);
    checkCounts("midframe_next_write", writesSeen - w0, 1);
    checkCounts("midframe_queue", expQ.size(), 0);
  endtask

  initial begin
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    test_reset();
    test_single_word();
    test_full_frame();
    test_back_to_back();
    test_timeout_partial();
    test_slow_gap();
    test_stall_resync();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
